// File: rtl/ctrl_seq.sv
// ctrl_seq: sequencing control unit between instruction fetch and datapath.
// Decodes the 15-opcode ISA, resolves branches against the ALU flag, stalls
// fetch while a load waits on data memory, and runs a start/halt handshake
// with a saturating cycle counter for the test harness.
//
// Ports:
//   Clk, Reset            clock; asynchronous active-high reset
//   Start                 begin/restart program (honoured in IDLE and HALT)
//   Instruction[IW-1:0]   current machine word; opcode in the top four bits
//   Flag                  ALU condition flag from the last sne/seq
//   PcEn, BranchEn        fetch advance / branch taken (BranchEn only with PcEn)
//   TargSel[1:0]          branch target select, taken straight from Instruction
//   RegWrEn, MemWrEn, MemRdEn, ALUEn, FlagWrEn   datapath enables
//   AluOp[3:0]            opcode when ALUEn, else 0
//   Stall                 load in progress, hold PC
//   Ack                   program halted
//   IllegalOp             sticky: reserved encoding executed
//   CycleCount[CNTW-1:0]  cycles spent running, saturating
module ctrl_seq #(
  parameter int unsigned IW      = 9,
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned CNTW    = 16
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic [IW-1:0]   Instruction,
  input  logic            Flag,
  output logic            PcEn,
  output logic            BranchEn,
  output logic [1:0]      TargSel,
  output logic            RegWrEn,
  output logic            MemWrEn,
  output logic            MemRdEn,
  output logic            ALUEn,
  output logic            FlagWrEn,
  output logic [3:0]      AluOp,
  output logic            Stall,
  output logic            Ack,
  output logic            IllegalOp,
  output logic [CNTW-1:0] CycleCount
);

  localparam int unsigned LATW = 4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_MEMWAIT = 2'd2,
    S_HALT    = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [LATW-1:0] wait_q, wait_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            illegal_q, illegal_d;

  logic [3:0] opcode;
  logic       is_halt;

  assign opcode  = Instruction[IW-1:IW-4];
  assign is_halt = &Instruction;

  // Target select is a raw field; at the narrowest width only one bit exists.
  if (IW >= 7) begin : g_targ_full
    assign TargSel = Instruction[IW-6:IW-7];
  end else begin : g_targ_narrow
    assign TargSel = {Instruction[0], 1'b0};
  end

  // State register and counters.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

  // Next state and state-qualified decode.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    cnt_d     = cnt_q;
    illegal_d = illegal_q;
    PcEn      = 1'b0;
    BranchEn  = 1'b0;
    RegWrEn   = 1'b0;
    MemWrEn   = 1'b0;
    MemRdEn   = 1'b0;
    ALUEn     = 1'b0;
    FlagWrEn  = 1'b0;
    Stall     = 1'b0;
    Ack       = 1'b0;

    if ((state_q == S_RUN || state_q == S_MEMWAIT) && cnt_q != {CNTW{1'b1}}) begin
      cnt_d = cnt_q + CNTW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d   = S_RUN;
          cnt_d     = '0;
          illegal_d = 1'b0;
        end
      end

      S_RUN: begin
        case (opcode)
          4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1110: begin
            ALUEn   = 1'b1;
            RegWrEn = 1'b1;
            PcEn    = 1'b1;
          end
          4'b1001, 4'b1010: begin
            ALUEn    = 1'b1;
            FlagWrEn = 1'b1;
            PcEn     = 1'b1;
          end
          4'b1000, 4'b1100: begin
            RegWrEn = 1'b1;
            PcEn    = 1'b1;
          end
          4'b0010, 4'b0011: begin
            MemWrEn = 1'b1;
            PcEn    = 1'b1;
          end
          4'b1011: begin
            PcEn     = 1'b1;
            BranchEn = Flag;
          end
          4'b1101: begin
            PcEn     = 1'b1;
            BranchEn = ~Flag;
          end
          4'b0000, 4'b0001: begin
            MemRdEn = 1'b1;
            if (MEM_LAT == 0) begin
              RegWrEn = 1'b1;
              PcEn    = 1'b1;
            end else begin
              Stall   = 1'b1;
              wait_d  = LATW'(MEM_LAT);
              state_d = S_MEMWAIT;
            end
          end
          4'b1111: begin
            // All-ones word halts; any other reserved word is a flagged NOP.
            if (is_halt) begin
              state_d = S_HALT;
            end else begin
              PcEn      = 1'b1;
              illegal_d = 1'b1;
            end
          end
          default: ;
        endcase
      end

      S_MEMWAIT: begin
        MemRdEn = 1'b1;
        wait_d  = wait_q - LATW'(1);
        // Last wait cycle writes back and releases fetch.
        if (wait_q <= LATW'(1)) begin
          RegWrEn = 1'b1;
          PcEn    = 1'b1;
          state_d = S_RUN;
        end else begin
          Stall = 1'b1;
        end
      end

      S_HALT: begin
        Ack = 1'b1;
        if (Start) begin
          state_d   = S_RUN;
          cnt_d     = '0;
          illegal_d = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase

    AluOp = ALUEn ? opcode : 4'd0;
  end

  assign IllegalOp  = illegal_q;
  assign CycleCount = cnt_q;

endmodule

// File: tb/tb_ctrl_seq.sv
// Bench for ctrl_seq: directed vector table, hand-written corner sequences and
// randomized stimulus against a behavioural model. Two instances share inputs:
// A has MEM_LAT=2/CNTW=16, B has MEM_LAT=0/CNTW=3.
module tb_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [8:0] instr = '0;
  logic       flag = 1'b0;

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc;
    logic       br;
    logic [1:0] ts;
    logic       rw;
    logic       mw;
    logic       mr;
    logic       alu;
    logic       fw;
    logic [3:0] op;
    logic       st;
    logic       ack;
    logic       ill;
  } outs_t;

  logic a_pc, a_br, a_rw, a_mw, a_mr, a_alu, a_fw, a_st, a_ack, a_ill;
  logic b_pc, b_br, b_rw, b_mw, b_mr, b_alu, b_fw, b_st, b_ack, b_ill;
  logic [1:0]  a_ts, b_ts;
  logic [3:0]  a_op, b_op;
  logic [15:0] a_cnt;
  logic [2:0]  b_cnt;
  outs_t a_o, b_o;

  assign a_o = {a_pc, a_br, a_ts, a_rw, a_mw, a_mr, a_alu, a_fw, a_op, a_st, a_ack, a_ill};
  assign b_o = {b_pc, b_br, b_ts, b_rw, b_mw, b_mr, b_alu, b_fw, b_op, b_st, b_ack, b_ill};

  ctrl_seq #(.IW(9), .MEM_LAT(2), .CNTW(16)) u_a (
    .Clk(clk), .Reset(rst), .Start(start), .Instruction(instr), .Flag(flag),
    .PcEn(a_pc), .BranchEn(a_br), .TargSel(a_ts), .RegWrEn(a_rw), .MemWrEn(a_mw),
    .MemRdEn(a_mr), .ALUEn(a_alu), .FlagWrEn(a_fw), .AluOp(a_op), .Stall(a_st),
    .Ack(a_ack), .IllegalOp(a_ill), .CycleCount(a_cnt)
  );

  ctrl_seq #(.IW(9), .MEM_LAT(0), .CNTW(3)) u_b (
    .Clk(clk), .Reset(rst), .Start(start), .Instruction(instr), .Flag(flag),
    .PcEn(b_pc), .BranchEn(b_br), .TargSel(b_ts), .RegWrEn(b_rw), .MemWrEn(b_mw),
    .MemRdEn(b_mr), .ALUEn(b_alu), .FlagWrEn(b_fw), .AluOp(b_op), .Stall(b_st),
    .Ack(b_ack), .IllegalOp(b_ill), .CycleCount(b_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Opcode effects table: what each instruction class asks of the datapath.
  typedef struct {
    bit alu;
    bit rw;
    bit fw;
    bit mw;
    bit ld;
    int br;  // 0 none, 1 on Flag, 2 on ~Flag
  } eff_t;
  eff_t eff[16];

  // Model: mode 0 idle, 1 running, 2 halted; load_age counts wait cycles done.
  int m_lat[2]  = '{2, 0};
  int m_cntw[2] = '{16, 3};
  int m_mode[2];
  int m_age[2];
  int m_cyc[2];
  bit m_ill[2];

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_age[k] = 0; m_cyc[k] = 0; m_ill[k] = 1'b0;
    end
  endfunction

  function automatic outs_t model_out(input int k, input logic [8:0] i, input logic f);
    outs_t o;
    eff_t  e;
    int    op;
    o = '0;
    o.ts  = i[3:2];
    o.ill = m_ill[k];
    op = int'(i[8:5]);
    if (m_mode[k] == 2) begin
      o.ack = 1'b1;
    end else if (m_mode[k] == 1) begin
      if (m_age[k] > 0) begin
        o.mr = 1'b1;
        if (m_age[k] == m_lat[k]) begin o.rw = 1'b1; o.pc = 1'b1; end
        else o.st = 1'b1;
      end else if (op == 15) begin
        o.pc = (i != 9'h1FF);
      end else begin
        e = eff[op];
        if (e.ld) begin
          o.mr = 1'b1;
          if (m_lat[k] == 0) begin o.rw = 1'b1; o.pc = 1'b1; end
          else o.st = 1'b1;
        end else begin
          o.pc  = 1'b1;
          o.alu = e.alu;
          o.rw  = e.rw;
          o.fw  = e.fw;
          o.mw  = e.mw;
          o.br  = (e.br == 1) ? f : (e.br == 2) ? ~f : 1'b0;
          o.op  = e.alu ? 4'(op) : 4'd0;
        end
      end
    end
    return o;
  endfunction

  function automatic int model_cnt(input int k);
    int cap;
    cap = (1 << m_cntw[k]) - 1;
    return (m_cyc[k] > cap) ? cap : m_cyc[k];
  endfunction

  function automatic void model_step(input int k, input logic s, input logic [8:0] i);
    int op;
    op = int'(i[8:5]);
    if (m_mode[k] == 1) begin
      m_cyc[k]++;
      if (m_age[k] > 0) begin
        m_age[k] = (m_age[k] == m_lat[k]) ? 0 : m_age[k] + 1;
      end else if (op == 15) begin
        if (i == 9'h1FF) m_mode[k] = 2;
        else m_ill[k] = 1'b1;
      end else if (eff[op].ld && m_lat[k] > 0) begin
        m_age[k] = 1;
      end
    end else if (s) begin
      m_mode[k] = 1; m_cyc[k] = 0; m_ill[k] = 1'b0;
    end
  endfunction

  outs_t snap_a, snap_b;
  int    snap_acnt, snap_bcnt;

  // One clock: apply inputs, compare both instances at negedge, advance model.
  task automatic cycle(input logic s, input logic [8:0] i, input logic f);
    outs_t ea, eb;
    start = s; instr = i; flag = f;
    if (rst) model_reset();
    @(negedge clk);
    ea = model_out(0, i, f);
    eb = model_out(1, i, f);
    snap_a = a_o; snap_b = b_o;
    snap_acnt = int'(a_cnt); snap_bcnt = int'(b_cnt);
    chk("model_a_outs", int'(a_o), int'(ea));
    chk("model_a_cnt", int'(a_cnt), model_cnt(0));
    chk("model_b_outs", int'(b_o), int'(eb));
    chk("model_b_cnt", int'(b_cnt), model_cnt(1));
    @(posedge clk);
    if (rst) model_reset();
    else begin
      model_step(0, s, i);
      model_step(1, s, i);
    end
    #1;
  endtask

  typedef struct {
    logic       s;
    logic [8:0] i;
    logic       f;
    outs_t      e;
    int         cnt;
  } vec_t;

  function automatic vec_t v(input logic s, input logic [8:0] i, input logic f,
                             input logic pc, input logic br, input logic rw, input logic mw,
                             input logic mr, input logic alu, input logic fw, input logic st,
                             input logic ack, input logic ill, input int op, input int cnt);
    vec_t r;
    r.s = s; r.i = i; r.f = f; r.cnt = cnt;
    r.e = '0;
    r.e.pc = pc; r.e.br = br; r.e.rw = rw; r.e.mw = mw; r.e.mr = mr;
    r.e.alu = alu; r.e.fw = fw; r.e.st = st; r.e.ack = ack; r.e.ill = ill;
    r.e.op = 4'(op);
    r.e.ts = i[3:2];
    return r;
  endfunction

  localparam logic [8:0] ADD = 9'b0101_00000;

  initial begin
    vec_t vt[18];
    logic [8:0] ri;
    int r;

    eff[0]  = '{0, 1, 0, 0, 1, 0};  // lw
    eff[1]  = '{0, 1, 0, 0, 1, 0};  // lwl
    eff[2]  = '{0, 0, 0, 1, 0, 0};  // sw
    eff[3]  = '{0, 0, 0, 1, 0, 0};  // swl
    eff[4]  = '{1, 1, 0, 0, 0, 0};  // xor
    eff[5]  = '{1, 1, 0, 0, 0, 0};  // add
    eff[6]  = '{1, 1, 0, 0, 0, 0};  // lsr
    eff[7]  = '{1, 1, 0, 0, 0, 0};  // lsl
    eff[8]  = '{0, 1, 0, 0, 0, 0};  // mov
    eff[9]  = '{1, 0, 1, 0, 0, 0};  // sne
    eff[10] = '{1, 0, 1, 0, 0, 0};  // seq
    eff[11] = '{0, 0, 0, 0, 0, 1};  // boo
    eff[12] = '{0, 1, 0, 0, 0, 0};  // lut
    eff[13] = '{0, 0, 0, 0, 0, 2};  // bol
    eff[14] = '{1, 1, 0, 0, 0, 0};  // msk
    eff[15] = '{0, 0, 0, 0, 0, 0};
    model_reset();

    //            s  instr          f  pc br rw mw mr al fw st ak il op cnt
    vt[0]  = v(1, 9'h000,        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0);
    vt[1]  = v(0, ADD,           0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 5,  0);
    vt[2]  = v(0, 9'b010000000,  0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 4,  1);
    vt[3]  = v(0, 9'b100000000,  0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0,  2);
    vt[4]  = v(0, 9'b001000000,  0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0,  3);
    vt[5]  = v(0, 9'b101000000,  1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 10, 4);
    vt[6]  = v(0, 9'b101100100,  1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  5);
    vt[7]  = v(0, 9'b110100000,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  6);
    vt[8]  = v(0, 9'b000000000,  0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0,  7);
    vt[9]  = v(0, ADD,           0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0,  8);
    vt[10] = v(0, ADD,           0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0,  9);
    vt[11] = v(0, ADD,           0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 5,  10);
    vt[12] = v(0, 9'b111100000,  0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  11);
    vt[13] = v(0, 9'b110000000,  0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0,  12);
    vt[14] = v(0, 9'h1FF,        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  13);
    vt[15] = v(0, ADD,           0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0,  14);
    vt[16] = v(1, ADD,           0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0,  14);
    vt[17] = v(0, ADD,           0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 5,  0);

    // Reset phase: outputs quiet while Reset is held.
    rst = 1'b1;
    cycle(1, ADD, 0);
    cycle(0, ADD, 0);
    chk("reset_a_cnt", snap_acnt, 0);
    rst = 1'b0;

    // Directed table against instance A.
    for (int n = 0; n < 18; n++) begin
      cycle(vt[n].s, vt[n].i, vt[n].f);
      chk($sformatf("vec%0d_outs", n), int'(snap_a), int'(vt[n].e));
      chk($sformatf("vec%0d_cnt", n), snap_acnt, vt[n].cnt);
    end

    // Zero-latency load completes in one cycle on B; A enters its wait.
    cycle(0, 9'b000100000, 0);
    chk("lat0_load", int'({snap_b.mr, snap_b.rw, snap_b.pc, snap_b.st}), 4'b1110);

    // Asynchronous reset while A is waiting on memory.
    #2 rst = 1'b1;
    #1;
    chk("areset_a_outs", int'({a_pc, a_rw, a_mr, a_st, a_ack, a_ill}), 0);
    chk("areset_a_cnt", int'(a_cnt), 0);
    model_reset();
    cycle(1, ADD, 0);
    rst = 1'b0;
    cycle(1, ADD, 0);
    chk("restart_idle_pc", int'(snap_a.pc), 0);
    cycle(0, ADD, 0);
    chk("restart_run_pc", int'(snap_a.pc), 1);

    // Halt word then ten idle cycles holding Ack with PcEn low.
    cycle(0, 9'h1FF, 0);
    for (int n = 0; n < 10; n++) begin
      cycle(0, 9'($urandom), 1'($urandom));
      chk("halt_hold", int'({snap_a.ack, snap_a.pc}), 2'b10);
    end
    cycle(1, ADD, 0);
    cycle(0, ADD, 0);
    chk("halt_restart_ack", int'(snap_a.ack), 0);
    chk("halt_restart_cnt", snap_acnt, 0);
    for (int n = 0; n < 9; n++) cycle(0, ADD, 0);
    chk("sat_b_cnt", int'(b_cnt), 7);
    chk("sat_a_cnt", int'(a_cnt), 10);

    // Randomized stream with occasional restarts, halts and resets.
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 19);
      if (r < 2) ri = 9'h1FF;
      else if (r == 2) ri = {4'hF, 5'($urandom)};
      else ri = 9'($urandom);
      rst = ($urandom_range(0, 199) == 0);
      cycle(($urandom_range(0, 3) == 0), ri, 1'($urandom));
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
